clk_div_monitor: RTL and testbench

- Downstream checker for the integer clock dividers; consumes a divided clock (asynchronous to its own logic) and measures its period in cycles of the source clock.
- Flags period deviation, missing edges and lock status, so integration logic can gate on a verified divided clock.
- Runs entirely in the source clock domain; the divided clock is treated as a data signal and is never used as a clock here.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_sync_edge_det.sv | 31 +++
 rtl/clk_div_monitor.sv | 137 +++++++++++++
 tb/tb_clk_div_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the integer clock-divider family.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    MEAS = 2'd2,
    LOCK = 2'd3
  } state_e;

  // Counter width able to hold the saturation value 2*ratio.
  function automatic int cw_for(input int ratio);
    return $clog2(2 * ratio + 1);
  endfunction

endpackage

// File: rtl/clk_div_sync_edge_det.sv
// Synchronizes an asynchronous level into i_clk and flags its rising edges.
module sync_edge_det
  import clk_div_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_async};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign o_sync = sync_r[SYNC_STAGES-1];
  assign o_rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in source-clock cycles and reports
// lock, sticky out-of-tolerance error and missing-edge timeout.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int RATIO       = 8,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_div_clk,
  input  logic                     i_clr_err,
  output logic [cw_for(RATIO)-1:0] o_period,
  output logic                     o_period_vld,
  output logic                     o_locked,
  output logic                     o_err,
  output logic                     o_timeout
);

  localparam int CW     = cw_for(RATIO);
  localparam int GW     = $clog2(LOCK_CNT + 1);
  localparam int TOL_LO = RATIO - TOL;
  localparam int TOL_HI = RATIO + TOL;
  localparam logic [CW-1:0] MAXP_V = CW'(2 * RATIO);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic [GW-1:0]   good_cnt_r;
  logic [GW-1:0]   good_nxt_s;
  logic            rise_s;
  logic            in_tol_s;
  logic            sync_unused_s;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_div_clk),
    .o_sync (sync_unused_s),
    .o_rise (rise_s)
  );

  // Next counter value, tolerance window and saturating good-period streak
  always_comb begin
    in_tol_s = (int'(cnt_r) >= TOL_LO) && (int'(cnt_r) <= TOL_HI);
    if (rise_s) begin
      cnt_nxt_s = CW'(1);
    end else if (cnt_r == MAXP_V) begin
      cnt_nxt_s = MAXP_V;
    end else begin
      cnt_nxt_s = cnt_r + 1'b1;
    end
    if (!in_tol_s) begin
      good_nxt_s = '0;
    end else if (good_cnt_r >= LOCK_V) begin
      good_nxt_s = LOCK_V;
    end else begin
      good_nxt_s = good_cnt_r + 1'b1;
    end
  end

  // Monitor FSM with registered outputs; a set of o_err overrides a clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      good_cnt_r   <= '0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_period_vld <= 1'b0;
      if (i_clr_err) begin
        o_err <= 1'b0;
      end
      if (!i_en) begin
        state_r    <= IDLE;
        cnt_r      <= '0;
        good_cnt_r <= '0;
        o_locked   <= 1'b0;
        o_timeout  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r      <= '0;
            good_cnt_r <= '0;
            o_locked   <= 1'b0;
            o_timeout  <= 1'b0;
            state_r    <= SEEK;
          end
          SEEK: begin
            cnt_r <= cnt_nxt_s;
            if (rise_s) begin
              o_timeout <= 1'b0;
              state_r   <= MEAS;
            end
          end
          MEAS, LOCK: begin
            cnt_r <= cnt_nxt_s;
            // A rise on the saturation cycle is a measurement, not a timeout
            if (rise_s) begin
              o_period     <= cnt_r;
              o_period_vld <= 1'b1;
              o_timeout    <= 1'b0;
              good_cnt_r   <= good_nxt_s;
              if (!in_tol_s) begin
                o_err    <= 1'b1;
                o_locked <= 1'b0;
                state_r  <= MEAS;
              end else if (good_nxt_s == LOCK_V) begin
                o_locked <= 1'b1;
                state_r  <= LOCK;
              end
            end else if (cnt_r == MAXP_V) begin
              o_locked   <= 1'b0;
              o_timeout  <= 1'b1;
              good_cnt_r <= '0;
              state_r    <= SEEK;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor: an event-level reference model feeds a
// scoreboard queue that a separate negedge monitor drains and compares.
module tb_clk_div_monitor;
  import clk_div_pkg::*;

  localparam int RATIO       = 8;
  localparam int TOL         = 1;
  localparam int LOCK_CNT    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MAXP        = 2 * RATIO;
  localparam int CW          = cw_for(RATIO);

  logic          i_clk     = 1'b0;
  logic          i_rst     = 1'b1;
  logic          i_en      = 1'b0;
  logic          i_div_clk = 1'b0;
  logic          i_clr_err = 1'b0;
  logic [CW-1:0] o_period;
  logic          o_period_vld;
  logic          o_locked;
  logic          o_err;
  logic          o_timeout;

  clk_div_monitor #(
    .RATIO(RATIO), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_div_clk   (i_div_clk),
    .i_clr_err   (i_clr_err),
    .o_period    (o_period),
    .o_period_vld(o_period_vld),
    .o_locked    (o_locked),
    .o_err       (o_err),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int period;
    bit locked;
    bit err;
  } exp_t;

  typedef enum {M_OFF, M_WAIT, M_RUN} mode_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state: edges are tracked by their cycle numbers
  mode_t mode      = M_OFF;
  bit    seen[3]   = '{1'b0, 1'b0, 1'b0};
  int    cyc       = 0;
  int    last_rise = 0;
  int    streak    = 0;
  int    m_period  = 0;
  bit    m_locked  = 1'b0;
  bit    m_err     = 1'b0;
  bit    m_to      = 1'b0;
  bit    m_rise;
  int    elapsed;
  exp_t  m_e;
  exp_t  got_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: divided clock is visible SYNC_STAGES+1 cycles after it is sampled
  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
      m_rise = seen[SYNC_STAGES-1] && !seen[SYNC_STAGES];
      if (i_rst) begin
        seen     = '{1'b0, 1'b0, 1'b0};
        mode     = M_OFF;
        streak   = 0;
        m_period = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_to     = 1'b0;
      end else begin
        seen[2] = seen[1];
        seen[1] = seen[0];
        seen[0] = i_div_clk;
        if (i_clr_err) m_err = 1'b0;
        if (!i_en) begin
          mode     = M_OFF;
          streak   = 0;
          m_locked = 1'b0;
          m_to     = 1'b0;
        end else begin
          case (mode)
            M_OFF: mode = M_WAIT;
            M_WAIT: begin
              if (m_rise) begin
                last_rise = cyc;
                m_to      = 1'b0;
                mode      = M_RUN;
              end
            end
            default: begin
              elapsed = cyc - last_rise;
              if (m_rise) begin
                m_period  = (elapsed > MAXP) ? MAXP : elapsed;
                last_rise = cyc;
                m_to      = 1'b0;
                if (m_period >= RATIO - TOL && m_period <= RATIO + TOL) begin
                  streak = (streak + 1 > LOCK_CNT) ? LOCK_CNT : streak + 1;
                  if (streak == LOCK_CNT) m_locked = 1'b1;
                end else begin
                  streak   = 0;
                  m_err    = 1'b1;
                  m_locked = 1'b0;
                end
                m_e.period = m_period;
                m_e.locked = m_locked;
                m_e.err    = m_err;
                sb_q.push_back(m_e);
              end else if (elapsed >= MAXP) begin
                mode     = M_WAIT;
                streak   = 0;
                m_locked = 1'b0;
                m_to     = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // Monitor: compares levels every cycle and drains the queue on each vld
  initial begin
    forever begin
      @(negedge i_clk);
      if (cyc > 0) begin
        check("locked", int'(o_locked), int'(m_locked));
        check("timeout", int'(o_timeout), int'(m_to));
        check("err", int'(o_err), int'(m_err));
        check("period_level", int'(o_period), m_period);
        n_checks++;
        if (o_period_vld) begin
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vld actual=1 expected=0 cycle=%0d", cyc);
          end else begin
            got_e = sb_q.pop_front();
            check("vld_period", int'(o_period), got_e.period);
            check("vld_locked", int'(o_locked), int'(got_e.locked));
            check("vld_err", int'(o_err), int'(got_e.err));
          end
        end else if (sb_q.size() > 0) begin
          n_fail++;
          $display("FAIL missing_vld actual=0 expected=1 cycle=%0d", cyc);
          sb_q.delete();
        end
      end
    end
  end

  task automatic drive_period(input int p, input int h, input int clr_lo, input int clr_hi);
    for (int i = 0; i < p; i++) begin
      @(posedge i_clk);
      #1;
      i_div_clk = (i < h);
      i_clr_err = (i >= clr_lo && i <= clr_hi);
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      i_div_clk = 1'b0;
      i_clr_err = 1'b0;
    end
  endtask

  initial begin
    int r;
    int p;
    int c;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_period", int'(o_period), 0);
    check("reset_locked", int'(o_locked), 0);
    i_rst = 1'b0;
    i_en  = 1'b1;

    // Steady divide-by-8: locks on the fourth measurement
    repeat (7) drive_period(8, 4, -1, -1);
    check("tp1_locked", int'(o_locked), 1);
    check("tp1_err", int'(o_err), 0);
    check("tp1_period", int'(o_period), 8);

    // One long period drops lock and sets the sticky error
    drive_period(11, 5, -1, -1);
    drive_period(8, 4, -1, -1);
    check("tp2_err", int'(o_err), 1);
    check("tp2_unlocked", int'(o_locked), 0);
    check("tp2_period", int'(o_period), 11);
    repeat (4) drive_period(8, 4, -1, -1);
    check("tp2_relock", int'(o_locked), 1);
    check("tp2_err_sticky", int'(o_err), 1);
    drive_period(8, 4, 5, 5);
    check("tp2_err_clr", int'(o_err), 0);

    // Alternating 7/9 stays within tolerance
    repeat (6) begin
      drive_period(7, 3, -1, -1);
      drive_period(9, 4, -1, -1);
    end
    check("tp3_locked", int'(o_locked), 1);
    check("tp3_err", int'(o_err), 0);

    // Stopped clock times out, then relocks after restart
    hold_low(24);
    check("tp4_timeout", int'(o_timeout), 1);
    check("tp4_unlocked", int'(o_locked), 0);
    repeat (6) drive_period(8, 4, -1, -1);
    check("tp4_to_clear", int'(o_timeout), 0);
    check("tp4_relock", int'(o_locked), 1);

    // Clear coincident with a bad measurement loses to the set
    drive_period(12, 6, -1, -1);
    drive_period(8, 4, 2, 2);
    check("tp5_set_wins", int'(o_err), 1);
    drive_period(12, 6, -1, -1);
    drive_period(8, 4, 2, 3);
    check("tp5_clr_next", int'(o_err), 0);

    // Reset mid-period while locked
    repeat (6) drive_period(8, 4, -1, -1);
    @(posedge i_clk); #1 i_div_clk = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    check("tp6_period", int'(o_period), 0);
    check("tp6_vld", int'(o_period_vld), 0);
    check("tp6_locked", int'(o_locked), 0);
    check("tp6_err", int'(o_err), 0);
    check("tp6_timeout", int'(o_timeout), 0);
    drive_period(6, 2, -1, -1);
    repeat (6) drive_period(8, 4, -1, -1);

    // Randomized mix of periods, stalls, enable drops, clears and resets
    repeat (250) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        p = int'($urandom_range(7, 9));
      end else begin
        p = int'($urandom_range(2, 20));
      end
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, p - 2)) : -1;
      if (r >= 85 && r < 90) begin
        hold_low(int'($urandom_range(10, 30)));
      end else if (r >= 95) begin
        @(posedge i_clk); #1 i_en = 1'b0;
        repeat (int'($urandom_range(1, 4))) @(posedge i_clk);
        #1 i_en = 1'b1;
      end else if (r == 94) begin
        @(posedge i_clk); #1 i_rst = 1'b1;
        @(posedge i_clk); #1 i_rst = 1'b0;
      end else begin
        drive_period(p, int'($urandom_range(1, p - 1)), c, c);
      end
    end

    hold_low(4);
    i_en = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("queue_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
